// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded operands/control, decodes the ALU
// select code, and forwards EX/MEM and MEM/WB results onto the ALU operands.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [15:0]       id_imm16,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [5:0]        id_funct,
    input  logic [1:0]        id_alu_op,
    input  logic              id_alu_src,
    input  logic              id_reg_dst,
    input  logic              id_reg_write,
    input  logic              exmem_reg_write,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_reg_write,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_result,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [3:0]        Sel,
    output logic [DATA_W-1:0] ex_store_data,
    output logic              ex_valid,
    output logic [REG_AW-1:0] ex_dest,
    output logic              ex_reg_write,
    output logic              ex_illegal
);

    logic [DATA_W-1:0] rs_data_q;
    logic [DATA_W-1:0] rt_data_q;
    logic [15:0]       imm_q;
    logic [REG_AW-1:0] rs_q;
    logic [REG_AW-1:0] rt_q;
    logic [REG_AW-1:0] dest_q;
    logic [1:0]        alu_op_q;
    logic              alu_src_q;
    logic              valid_q;
    logic              reg_write_q;
    logic [3:0]        sel_q;
    logic              illegal_q;

    logic [3:0]        dec_sel;
    logic              dec_illegal;

    always_comb begin
        dec_sel     = 4'b0000;
        dec_illegal = 1'b0;
        case (id_alu_op)
            2'b00: dec_sel = 4'b0010;
            2'b01: dec_sel = 4'b0110;
            2'b11: dec_sel = 4'b0001;
            default: begin
                case (id_funct)
                    6'b100000: dec_sel = 4'b0010;
                    6'b100010: dec_sel = 4'b0110;
                    6'b100100: dec_sel = 4'b0000;
                    6'b100101: dec_sel = 4'b0001;
                    6'b101010: dec_sel = 4'b0111;
                    6'b100111: dec_sel = 4'b1100;
                    default:   dec_illegal = id_valid;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            imm_q       <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            dest_q      <= '0;
            alu_op_q    <= '0;
            alu_src_q   <= 1'b0;
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            sel_q       <= '0;
            illegal_q   <= 1'b0;
        end else if (!stall) begin
            rs_data_q   <= id_rs_data;
            rt_data_q   <= id_rt_data;
            imm_q       <= id_imm16;
            rs_q        <= id_rs;
            rt_q        <= id_rt;
            dest_q      <= id_reg_dst ? id_rd : id_rt;
            alu_op_q    <= id_alu_op;
            alu_src_q   <= id_alu_src;
            valid_q     <= id_valid;
            reg_write_q <= id_reg_write & id_valid;
            sel_q       <= dec_sel;
            illegal_q   <= dec_illegal;
        end
    end

    // Register 0 is hardwired, so it never takes a forwarded value.
    function automatic logic [DATA_W-1:0] fwd(
        input logic [REG_AW-1:0] idx,
        input logic [DATA_W-1:0] stored
    );
        logic [DATA_W-1:0] r;
        r = stored;
        if (idx != '0) begin
            if (exmem_reg_write && exmem_rd == idx)
                r = exmem_result;
            else if (memwb_reg_write && memwb_rd == idx)
                r = memwb_result;
        end
        return r;
    endfunction

    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;
    logic [DATA_W-1:0] imm_ext;

    always_comb begin
        fwd_rs  = fwd(rs_q, rs_data_q);
        fwd_rt  = fwd(rt_q, rt_data_q);
        imm_ext = (alu_op_q == 2'b11)
                ? {{(DATA_W-16){1'b0}}, imm_q}
                : {{(DATA_W-16){imm_q[15]}}, imm_q};
    end

    assign A             = fwd_rs;
    assign B             = alu_src_q ? imm_ext : fwd_rt;
    assign ex_store_data = fwd_rt;
    assign Sel           = sel_q;
    assign ex_valid      = valid_q;
    assign ex_dest       = dest_q;
    assign ex_reg_write  = reg_write_q;
    assign ex_illegal    = illegal_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: expected outputs are queued as each step is
// driven and compared field by field once the stage has produced them.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        id_valid;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic [15:0] id_imm16;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [5:0]  id_funct;
    logic [1:0]  id_alu_op;
    logic        id_alu_src;
    logic        id_reg_dst;
    logic        id_reg_write;
    logic        exmem_reg_write;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_result;
    logic        memwb_reg_write;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_result;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  Sel;
    logic [31:0] ex_store_data;
    logic        ex_valid;
    logic [4:0]  ex_dest;
    logic        ex_reg_write;
    logic        ex_illegal;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        string       tag;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  sel;
        logic [31:0] sd;
        logic        v;
        logic [4:0]  dest;
        logic        rw;
        logic        ill;
    } exp_t;

    exp_t sb[$];

    id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_rs_data(id_rs_data),
        .id_rt_data(id_rt_data), .id_imm16(id_imm16),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_funct(id_funct), .id_alu_op(id_alu_op),
        .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
        .id_reg_write(id_reg_write),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
        .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd),
        .memwb_result(memwb_result),
        .A(A), .B(B), .Sel(Sel), .ex_store_data(ex_store_data),
        .ex_valid(ex_valid), .ex_dest(ex_dest),
        .ex_reg_write(ex_reg_write), .ex_illegal(ex_illegal)
    );

    always #5 clk = ~clk;

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(
        input logic v, input logic [31:0] rsd, input logic [31:0] rtd,
        input logic [15:0] imm, input logic [4:0] rs, input logic [4:0] rt,
        input logic [4:0] rd, input logic [5:0] fn, input logic [1:0] op,
        input logic src, input logic dst, input logic rw
    );
        id_valid = v;     id_rs_data = rsd; id_rt_data = rtd;
        id_imm16 = imm;   id_rs = rs;       id_rt = rt;
        id_rd = rd;       id_funct = fn;    id_alu_op = op;
        id_alu_src = src; id_reg_dst = dst; id_reg_write = rw;
    endtask

    task automatic set_fwd(
        input logic erw, input logic [4:0] erd, input logic [31:0] eres,
        input logic mrw, input logic [4:0] mrd, input logic [31:0] mres
    );
        exmem_reg_write = erw; exmem_rd = erd; exmem_result = eres;
        memwb_reg_write = mrw; memwb_rd = mrd; memwb_result = mres;
    endtask

    task automatic expect_out(
        input string tag, input logic [31:0] a, input logic [31:0] b,
        input logic [3:0] sel, input logic [31:0] sd, input logic v,
        input logic [4:0] dest, input logic rw, input logic ill
    );
        exp_t e;
        e.tag = tag; e.a = a; e.b = b; e.sel = sel; e.sd = sd;
        e.v = v; e.dest = dest; e.rw = rw; e.ill = ill;
        sb.push_back(e);
    endtask

    task automatic chk();
        exp_t e;
        n_assert++;
        assert (sb.size() > 0) else begin
            n_fail++;
            $error("FAIL scoreboard_empty: got 0 entries, need 1");
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_assert++;
            assert (A === e.a) else begin
                n_fail++;
                $error("FAIL %s A: got %h exp %h", e.tag, A, e.a);
            end
            n_assert++;
            assert (B === e.b) else begin
                n_fail++;
                $error("FAIL %s B: got %h exp %h", e.tag, B, e.b);
            end
            n_assert++;
            assert (Sel === e.sel) else begin
                n_fail++;
                $error("FAIL %s Sel: got %b exp %b", e.tag, Sel, e.sel);
            end
            n_assert++;
            assert (ex_store_data === e.sd) else begin
                n_fail++;
                $error("FAIL %s store: got %h exp %h",
                       e.tag, ex_store_data, e.sd);
            end
            n_assert++;
            assert (ex_valid === e.v) else begin
                n_fail++;
                $error("FAIL %s valid: got %b exp %b", e.tag, ex_valid, e.v);
            end
            n_assert++;
            assert (ex_dest === e.dest) else begin
                n_fail++;
                $error("FAIL %s dest: got %0d exp %0d",
                       e.tag, ex_dest, e.dest);
            end
            n_assert++;
            assert (ex_reg_write === e.rw) else begin
                n_fail++;
                $error("FAIL %s reg_write: got %b exp %b",
                       e.tag, ex_reg_write, e.rw);
            end
            n_assert++;
            assert (ex_illegal === e.ill) else begin
                n_fail++;
                $error("FAIL %s illegal: got %b exp %b",
                       e.tag, ex_illegal, e.ill);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        set_fwd($urandom_range(0, 1), 5'($urandom), $urandom,
                $urandom_range(0, 1), 5'($urandom), $urandom);
        set_id(1'($urandom), $urandom, $urandom, 16'($urandom),
               5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom),
               2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        expect_out("reset", 0, 0, 4'b0000, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk();

        // Reset release and first R-type load (nor)
        rst_n = 1'b1;
        set_fwd(0, 0, 0, 0, 0, 0);
        set_id(1, 32'd3, 32'd4, 16'h0, 5'd1, 5'd2, 5'd3,
               6'b100111, 2'b10, 0, 1, 1);
        expect_out("rtype_nor", 3, 4, 4'b1100, 4, 1, 3, 1, 0);
        clk1(); chk();

        set_id(1, 32'd10, 32'd5, 16'hFFFE, 5'd1, 5'd2, 5'd3,
               6'b0, 2'b00, 1, 0, 1);
        expect_out("imm_sext", 10, 32'hFFFF_FFFE, 4'b0010, 5, 1, 2, 1, 0);
        clk1(); chk();

        set_id(1, 32'd10, 32'd5, 16'hFFFE, 5'd1, 5'd2, 5'd3,
               6'b0, 2'b11, 1, 0, 1);
        expect_out("imm_zext", 10, 32'h0000_FFFE, 4'b0001, 5, 1, 2, 1, 0);
        clk1(); chk();

        set_id(1, 32'd10, 32'd5, 16'h8000, 5'd1, 5'd2, 5'd3,
               6'b0, 2'b00, 1, 0, 1);
        expect_out("imm_8000_s", 10, 32'hFFFF_8000, 4'b0010, 5, 1, 2, 1, 0);
        clk1(); chk();

        set_id(1, 32'd10, 32'd5, 16'h8000, 5'd1, 5'd2, 5'd3,
               6'b0, 2'b11, 1, 0, 1);
        expect_out("imm_8000_z", 10, 32'h0000_8000, 4'b0001, 5, 1, 2, 1, 0);
        clk1(); chk();

        set_id(1, 32'd7, 32'd8, 16'h0, 5'd1, 5'd2, 5'd3,
               6'b101010, 2'b10, 0, 1, 1);
        expect_out("rtype_slt", 7, 8, 4'b0111, 8, 1, 3, 1, 0);
        clk1(); chk();

        // Forwarding priority
        set_id(1, 32'd1, 32'd2, 16'h0, 5'd5, 5'd6, 5'd0,
               6'b0, 2'b00, 0, 0, 1);
        expect_out("fwd_none", 1, 2, 4'b0010, 2, 1, 6, 1, 0);
        clk1(); chk();

        set_fwd(1, 5'd5, 32'hAA, 1, 5'd5, 32'hBB);
        expect_out("fwd_exmem", 32'hAA, 2, 4'b0010, 2, 1, 6, 1, 0);
        #1; chk();

        exmem_reg_write = 1'b0;
        expect_out("fwd_memwb", 32'hBB, 2, 4'b0010, 2, 1, 6, 1, 0);
        #1; chk();

        set_fwd(1, 5'd0, 32'hAA, 1, 5'd0, 32'hBB);
        set_id(1, 32'h77, 32'd2, 16'h0, 5'd0, 5'd6, 5'd0,
               6'b0, 2'b00, 0, 0, 1);
        expect_out("fwd_r0", 32'h77, 2, 4'b0010, 2, 1, 6, 1, 0);
        clk1(); chk();

        // Stall holds the stage while decode keeps changing
        set_fwd(0, 0, 0, 0, 0, 0);
        set_id(1, 32'd11, 32'd22, 16'h0, 5'd1, 5'd2, 5'd9,
               6'b100000, 2'b10, 0, 1, 1);
        expect_out("add_load", 11, 22, 4'b0010, 22, 1, 9, 1, 0);
        clk1(); chk();

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_id(1'(i), 32'(100 + i), 32'(200 + i), 16'(i),
                   5'(10 + i), 5'(20 + i), 5'(4 + i),
                   6'b100010, 2'b01, 1, 1, 0);
            if (i == 2) begin
                set_fwd(0, 0, 0, 1, 5'd1, 32'h55);
                expect_out("stall_fwd", 32'h55, 22, 4'b0010, 22, 1, 9, 1, 0);
            end else begin
                expect_out("stall_hold", 11, 22, 4'b0010, 22, 1, 9, 1, 0);
            end
            clk1(); chk();
        end

        flush = 1'b1;
        expect_out("flush_stall", 0, 0, 4'b0000, 0, 0, 0, 0, 0);
        clk1(); chk();
        flush = 1'b0; stall = 1'b0;
        set_fwd(0, 0, 0, 0, 0, 0);

        // Unknown funct
        set_id(1, 32'd1, 32'd2, 16'h0, 5'd1, 5'd2, 5'd3,
               6'b000000, 2'b10, 0, 1, 1);
        expect_out("illegal_v1", 1, 2, 4'b0000, 2, 1, 3, 1, 1);
        clk1(); chk();

        set_id(0, 32'd1, 32'd2, 16'h0, 5'd1, 5'd2, 5'd3,
               6'b000000, 2'b10, 0, 1, 1);
        expect_out("illegal_v0", 1, 2, 4'b0000, 2, 0, 3, 0, 0);
        clk1(); chk();

        // Destination select and forwarded store data
        set_id(1, 32'd3, 32'd5, 16'h0010, 5'd1, 5'd7, 5'd9,
               6'b0, 2'b00, 1, 0, 0);
        expect_out("dest_rt", 3, 32'h10, 4'b0010, 5, 1, 7, 0, 0);
        clk1(); chk();

        set_fwd(0, 0, 0, 1, 5'd7, 32'h1234);
        expect_out("store_fwd", 3, 32'h10, 4'b0010, 32'h1234, 1, 7, 0, 0);
        #1; chk();

        // Reset wins over a simultaneous flush and stall
        set_fwd(0, 0, 0, 0, 0, 0);
        stall = 1'b1; flush = 1'b1; rst_n = 1'b0;
        expect_out("reset_prio", 0, 0, 4'b0000, 0, 0, 0, 0, 0);
        clk1(); chk();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
